// File: rtl/recorder_pkg.sv
// Shared types and width helpers for the sample recorder.
//   rec_state_t : controller state encoding
//   len_width() : width of a sample count that can hold 0..2**aw inclusive
package recorder_pkg;

  typedef enum logic [1:0] {IDLE, RECORD, PLAY} rec_state_t;

  localparam int unsigned DEF_ADDRESS_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH    = 8;

  // One extra bit so a completely full memory (2**aw samples) is representable.
  function automatic int unsigned len_width(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/sample_recorder_if.sv
// Stream and RAM-port bundle for the sample recorder.
//   in_valid/in_data/in_ready    : sample input stream
//   out_valid/out_data/out_ready : sample output stream
//   ram_wr_en/ram_addr/ram_din   : to the single-port RAM
//   ram_dout                     : async read data from the RAM
// modport master: recorder side; modport slave: source/sink/RAM side.
interface sample_recorder_if
  import recorder_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH
);

  logic                     in_valid;
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_ready;
  logic                     ram_wr_en;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_din;
  logic [DATA_WIDTH-1:0]    ram_dout;

  modport master (
    input  in_valid, in_data, out_ready, ram_dout,
    output in_ready, out_valid, out_data, ram_wr_en, ram_addr, ram_din
  );

  modport slave (
    output in_valid, in_data, out_ready, ram_dout,
    input  in_ready, out_valid, out_data, ram_wr_en, ram_addr, ram_din
  );

endinterface

// File: rtl/ptr_counter.sv
// Address pointer with clear, increment and terminal compare.
//   clk, rst : clock, synchronous active-high reset
//   clr      : load zero (wins over inc)
//   inc      : advance by one (wraps naturally at 2**WIDTH)
//   last     : terminal value to compare against
//   count    : current pointer value
//   at_last  : count == last
module ptr_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             at_last
);

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + One;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_last = (count_q == last);

endmodule

// File: rtl/sample_recorder.sv
// Sequential record/playback controller for an async-read single-port RAM.
// Records a sample stream into addresses 0.. and plays it back once or looped.
//   clk, rst          : clock, synchronous active-high reset
//   start_rec         : begin recording (IDLE only, wins over start_play)
//   start_play, loop  : begin playback, loop selects wrap-around
//   stop              : abort record/play
//   bus (master)      : input stream, output stream and RAM port
//   rec_len           : number of stored samples (0..2**ADDRESS_WIDTH)
//   busy              : not IDLE
//   done              : one-cycle pulse in the first IDLE cycle after record/play
module sample_recorder
  import recorder_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_rec,
  input  logic                  start_play,
  input  logic                  loop,
  input  logic                  stop,
  sample_recorder_if.master     bus,
  output logic [ADDRESS_WIDTH:0] rec_len,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LenW = len_width(ADDRESS_WIDTH);
  localparam logic [LenW-1:0] LenOne = {{(LenW-1){1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH-1:0] AddrMax = '1;

  rec_state_t state_q, state_d;
  logic [LenW-1:0] rec_len_q, rec_len_d;
  logic            loop_q, loop_d;
  logic            done_q, done_d;

  logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                     wr_at_last, rd_at_last;
  logic [LenW-1:0]          len_m1;
  logic                     accept, handshake, rec_start, play_start;

  // Index of the final stored sample; only meaningful while rec_len != 0.
  assign len_m1 = rec_len_q - LenOne;

  assign accept     = (state_q == RECORD) && bus.in_valid;
  assign handshake  = (state_q == PLAY) && bus.out_ready;
  assign rec_start  = (state_q == IDLE) && start_rec;
  assign play_start = (state_q == IDLE) && !start_rec && start_play && (rec_len_q != '0);

  ptr_counter #(
    .WIDTH (ADDRESS_WIDTH)
  ) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .clr     (rec_start),
    .inc     (accept),
    .last    (AddrMax),
    .count   (wr_ptr),
    .at_last (wr_at_last)
  );

  ptr_counter #(
    .WIDTH (ADDRESS_WIDTH)
  ) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .clr     (play_start || (handshake && rd_at_last && loop_q)),
    .inc     (handshake && !rd_at_last),
    .last    (len_m1[ADDRESS_WIDTH-1:0]),
    .count   (rd_ptr),
    .at_last (rd_at_last)
  );

  always_comb begin
    state_d   = state_q;
    rec_len_d = rec_len_q;
    loop_d    = loop_q;

    unique case (state_q)
      IDLE: begin
        if (rec_start) begin
          state_d   = RECORD;
          rec_len_d = '0;
        end else if (play_start) begin
          state_d = PLAY;
          loop_d  = loop;
        end
      end
      RECORD: begin
        // A sample accepted together with stop is still counted.
        if (accept) begin
          rec_len_d = rec_len_q + LenOne;
        end
        if (stop || (accept && wr_at_last)) begin
          state_d = IDLE;
        end
      end
      PLAY: begin
        if (stop || (handshake && rd_at_last && !loop_q)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rec_len_q <= '0;
      loop_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rec_len_q <= rec_len_d;
      loop_q    <= loop_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == RECORD);
    bus.out_valid = (state_q == PLAY);
    bus.out_data  = bus.ram_dout;
    bus.ram_wr_en = accept;
    bus.ram_din   = bus.in_data;
    unique case (state_q)
      RECORD:  bus.ram_addr = wr_ptr;
      PLAY:    bus.ram_addr = rd_ptr;
      default: bus.ram_addr = '0;
    endcase
  end

  assign rec_len = rec_len_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_sample_recorder.sv
module tb_sample_recorder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_rec, start_play, loop, stop;
  logic [8:0] rec_len;
  logic       busy, done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_q [3];
  logic       rdy_pat [6];

  sample_recorder_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) intf ();

  sample_recorder #(
    .ADDRESS_WIDTH (8),
    .DATA_WIDTH    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_rec  (start_rec),
    .start_play (start_play),
    .loop       (loop),
    .stop       (stop),
    .bus        (intf.master),
    .rec_len    (rec_len),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // RAM model: write on rising edge, asynchronous read.
  always @(posedge clk) begin
    if (intf.ram_wr_en) mem[intf.ram_addr] <= intf.ram_din;
  end
  assign intf.ram_dout = mem[intf.ram_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int idx;
    exp_q[0] = 8'h10; exp_q[1] = 8'h11; exp_q[2] = 8'h12;
    rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0;
    rdy_pat[3] = 1'b1; rdy_pat[4] = 1'b0; rdy_pat[5] = 1'b1;

    rst = 1'b1; start_rec = 1'b0; start_play = 1'b0; loop = 1'b0; stop = 1'b0;
    intf.in_valid = 1'b0; intf.in_data = '0; intf.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", intf.in_ready, 0);
    chk("rst_out_valid", intf.out_valid, 0);
    chk("rst_wr_en", intf.ram_wr_en, 0);
    chk("rst_addr", intf.ram_addr, 0);
    chk("rst_rec_len", rec_len, 0);
    chk("rst_done", done, 0);

    // start_play with nothing recorded is ignored
    start_play = 1'b1;
    tick();
    start_play = 1'b0;
    chk("empty_play_busy", busy, 0);
    tick();
    chk("empty_play_done", done, 0);

    // both commands at once: record wins; stream 0x10..0x12 then stop
    start_rec = 1'b1; start_play = 1'b1;
    tick();
    start_rec = 1'b0; start_play = 1'b0;
    intf.in_valid = 1'b1; intf.in_data = 8'h10;
    #1;
    chk("rec_busy", busy, 1);
    chk("rec_in_ready", intf.in_ready, 1);
    chk("rec_out_valid", intf.out_valid, 0);
    chk("rec_wr_en", intf.ram_wr_en, 1);
    chk("rec_addr0", intf.ram_addr, 0);
    chk("rec_din0", intf.ram_din, 8'h10);
    tick();
    intf.in_data = 8'h11;
    #1;
    chk("rec_addr1", intf.ram_addr, 1);
    tick();
    intf.in_data = 8'h12;
    #1;
    chk("rec_addr2", intf.ram_addr, 2);
    tick();
    intf.in_valid = 1'b0;
    stop = 1'b1;
    #1;
    chk("rec_len_3", rec_len, 3);
    chk("rec_no_wr_idle_valid", intf.ram_wr_en, 0);
    tick();
    stop = 1'b0;
    chk("rec_stop_done", done, 1);
    chk("rec_stop_busy", busy, 0);
    chk("rec_stop_len", rec_len, 3);
    chk("mem0", mem[0], 8'h10);
    chk("mem1", mem[1], 8'h11);
    chk("mem2", mem[2], 8'h12);
    tick();
    chk("rec_done_one_cycle", done, 0);

    // single playback, sink always ready
    start_play = 1'b1; loop = 1'b0;
    tick();
    start_play = 1'b0;
    intf.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("play_valid", intf.out_valid, 1);
      chk("play_addr", intf.ram_addr, i);
      chk("play_data", intf.out_data, exp_q[i]);
      tick();
    end
    chk("play_end_done", done, 1);
    chk("play_end_busy", busy, 0);
    chk("play_end_valid", intf.out_valid, 0);
    intf.out_ready = 1'b0;
    tick();
    chk("play_done_one_cycle", done, 0);

    // playback with a stalling sink: each sample held until taken
    start_play = 1'b1;
    tick();
    start_play = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      intf.out_ready = rdy_pat[c];
      #1;
      chk("stall_valid", intf.out_valid, 1);
      chk("stall_data", intf.out_data, exp_q[idx]);
      if (rdy_pat[c]) idx++;
      tick();
    end
    intf.out_ready = 1'b0;
    chk("stall_end_done", done, 1);
    chk("stall_end_busy", busy, 0);
    tick();

    // looped playback, no bubble at the wrap, stop mid-stream
    start_play = 1'b1; loop = 1'b1;
    tick();
    start_play = 1'b0; loop = 1'b0;
    intf.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("loop_valid", intf.out_valid, 1);
      chk("loop_data", intf.out_data, exp_q[i % 3]);
      tick();
    end
    stop = 1'b1;
    #1;
    chk("loop_pre_stop_data", intf.out_data, exp_q[2]);
    tick();
    stop = 1'b0;
    intf.out_ready = 1'b0;
    chk("loop_stop_done", done, 1);
    chk("loop_stop_busy", busy, 0);
    chk("loop_stop_len", rec_len, 3);
    tick();

    // reset during playback: back to IDLE, length lost, no done pulse
    start_play = 1'b1; loop = 1'b1;
    tick();
    start_play = 1'b0; loop = 1'b0;
    intf.out_ready = 1'b1;
    tick();
    chk("rstplay_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    intf.out_ready = 1'b0;
    chk("rstplay_busy", busy, 0);
    chk("rstplay_len", rec_len, 0);
    chk("rstplay_done", done, 0);
    tick();
    chk("rstplay_done_later", done, 0);

    // fill the whole memory; recording stops by itself
    start_rec = 1'b1;
    tick();
    start_rec = 1'b0;
    intf.in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      intf.in_data = 8'(i) ^ 8'hA5;
      #1;
      chk("full_addr", intf.ram_addr, i);
      tick();
    end
    intf.in_data = 8'hEE;
    #1;
    chk("full_done", done, 1);
    chk("full_busy", busy, 0);
    chk("full_len", rec_len, 256);
    chk("full_in_ready", intf.in_ready, 0);
    chk("full_no_write", intf.ram_wr_en, 0);
    chk("full_mem0", mem[0], 8'hA5);
    chk("full_mem255", mem[255], 8'h5A);
    tick();
    chk("full_len_hold", rec_len, 256);
    chk("full_mem0_kept", mem[0], 8'hA5);
    intf.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
